// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell is reused over WIDTH cycles, LSB first.
// The running carry lives in a flop and sum bits shift in from the MSB side of S.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C_out
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cy_q, cy_d;
    logic               c_out_q, c_out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fa_s, fa_c;

    full_adder u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (cy_q),
        .s  (fa_s),
        .co (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_d     = s_q;
        cy_d    = cy_q;
        c_out_d = c_out_q;
        cnt_d   = cnt_q;

        case (state_q)
            ADD: begin
                s_d    = {fa_s, s_q[WIDTH-1:1]};
                cy_d   = fa_c;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == LAST_BIT) begin
                    c_out_d = fa_c;
                    state_d = DONE;
                end
            end
            IDLE, DONE: begin
                // Start is honoured in both IDLE and DONE so results can stream back-to-back.
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    cy_d    = C_in;
                    s_d     = '0;
                    cnt_d   = '0;
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_q     <= '0;
            cy_q    <= 1'b0;
            c_out_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_q     <= s_d;
            cy_q    <= cy_d;
            c_out_q <= c_out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy  = (state_q == ADD);
    assign done  = (state_q == DONE);
    assign S     = s_q;
    assign C_out = c_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: expected {C_out,S} queued at start, checked on done.

module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             C_out;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    logic [WIDTH:0] sb_q[$];

    serial_adder_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .C_in  (C_in),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .C_out (C_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    endfunction

    // Result monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            check("busy_done_excl", {63'd0, busy & done}, 64'd0);
            if (done) begin
                done_pulses++;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    logic [WIDTH:0] exp_v;
                    exp_v = sb_q.pop_front();
                    $display("txn S=%02h C_out=%0b expected S=%02h C_out=%0b",
                             S, C_out, exp_v[WIDTH-1:0], exp_v[WIDTH]);
                    check("result", {55'd0, C_out, S}, {55'd0, exp_v});
                end
            end
        end
    end

    // Drives start for exactly one rising edge; returns just after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        @(negedge clk);
        A = a; B = b; C_in = c; start = 1'b1;
        sb_q.push_back(model(a, b, c));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges until done; n0/b0 account for cycles already spent by the caller.
    task automatic wait_done(input string tag, input int n0, input int b0);
        int n;
        int bc;
        n = n0;
        bc = b0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
            if (done) break;
        end
        check({tag, "_latency"}, 64'(n), 64'(WIDTH + 1));
        check({tag, "_busy_cycles"}, 64'(bc), 64'(WIDTH));
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c);
        start_op(a, b, c);
        wait_done(tag, 0, 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int p0;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; C_in = 1'b0;
        #3;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_S", {56'd0, S}, 64'd0);
        check("rst_C_out", {63'd0, C_out}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("zero", 8'h00, 8'h00, 1'b0);
        run_op("carry_chain", 8'hFF, 8'h01, 1'b0);
        run_op("a5_5a_cin", 8'hA5, 8'h5A, 1'b1);
        run_op("3c_42", 8'h3C, 8'h42, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_S", {56'd0, S}, 64'h7E);

        // Start and operand changes during ADD must be ignored.
        p0 = done_pulses;
        start_op(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        A = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = 8'h00;
        wait_done("ignore_start", 4, 4);
        repeat (12) @(negedge clk);
        check("ignore_start_pulses", 64'(done_pulses - p0), 64'd1);
        check("ignore_start_idle", {63'd0, busy}, 64'd0);

        // Back-to-back: start held high through DONE.
        @(negedge clk);
        A = 8'h01; B = 8'h01; C_in = 1'b0; start = 1'b1;
        sb_q.push_back(model(8'h01, 8'h01, 1'b0));
        sb_q.push_back(model(8'h01, 8'h01, 1'b0));
        @(posedge clk);
        #1;
        wait_done("b2b_first", 0, 0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("b2b_second", 0, 0);

        // Asynchronous reset mid-operation abandons the operation.
        repeat (2) @(negedge clk);
        start_op(8'hF0, 8'h0F, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        sb_q.delete();
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_done", {63'd0, done}, 64'd0);
        check("async_rst_S", {56'd0, S}, 64'd0);
        check("async_rst_C_out", {63'd0, C_out}, 64'd0);
        p0 = done_pulses;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("async_rst_no_done", 64'(done_pulses - p0), 64'd0);
        run_op("after_rst", 8'h01, 8'h02, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_op("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
